// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman frame sequencer.
// Symbol range bounds the values the encoder core can count.
package huffman_pkg;

  localparam int HF_FRAME_LEN = 100;

  localparam logic [7:0] SYM_MIN = 8'd1;
  localparam logic [7:0] SYM_MAX = 8'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_WAIT_CNT,
    ST_WAIT_CODE,
    ST_DONE,
    ST_ERR
  } hf_ctrl_state_t;

  function automatic logic sym_bad(
    input logic [7:0] s
  );
    return (s < SYM_MIN) || (s > SYM_MAX);
  endfunction

endpackage

// File: rtl/huffman_frame_ctrl_if.sv
// Upstream pixel valid/ready channel.
// The source drives master, the sequencer takes slave.
interface huffman_frame_ctrl_if;

  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );

endinterface

// File: rtl/huffman_wdog.sv
// Wait-state watchdog: clear on entry, count while enabled.
// expire_o fires on the TIMEOUT-th enabled cycle.
module huffman_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer: clears the Huffman core, meters one frame
// of pixels into it and watches for completion or timeout.
module huffman_frame_ctrl
  import huffman_pkg::*;
#(
  parameter int FRAME_LEN  = HF_FRAME_LEN,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int FCNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  huffman_frame_ctrl_if.slave  src,
  output logic                 core_rst,
  output logic                 gray_valid,
  output logic [7:0]           gray_data,
  input  logic                 CNT_valid,
  input  logic                 code_valid,
  output logic                 done,
  output logic                 err,
  output logic [6:0]           bad_cnt,
  output logic [FCNT_W-1:0]    frame_cnt
);

  localparam int PIX_W = $clog2(FRAME_LEN + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  hf_ctrl_state_t state_q, state_d;

  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              core_rst_q, core_rst_d;
  logic              gv_q, gv_d;
  logic [7:0]        gd_q, gd_d;
  logic              err_q, err_d;
  logic [6:0]        bad_q, bad_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic hs;
  logic wd_clr;
  logic wd_en;
  logic wd_exp;

  assign src.src_ready = (state_q == ST_FEED) &&
                         (pix_q < PIX_W'(FRAME_LEN));
  assign hs = src.src_valid && src.src_ready;

  assign wd_en = (state_q == ST_WAIT_CNT) ||
                 (state_q == ST_WAIT_CODE);

  huffman_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    clr_d   = clr_q;
    gv_d    = 1'b0;
    gd_d    = gd_q;
    err_d   = err_q;
    bad_d   = bad_q;
    fcnt_d  = fcnt_q;
    wd_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
          err_d   = 1'b0;
          bad_d   = '0;
          clr_d   = CLR_W'(CLR_CYCLES - 1);
          pix_d   = '0;
        end
      end
      ST_CLR: begin
        if (clr_q == '0) begin
          state_d = ST_FEED;
        end else begin
          clr_d = clr_q - 1'b1;
        end
      end
      ST_FEED: begin
        if (hs) begin
          gv_d  = 1'b1;
          gd_d  = src.src_data;
          pix_d = pix_q + 1'b1;
          // Out-of-range pixels still go to the core.
          if (sym_bad(src.src_data) && bad_q != 7'h7f) begin
            bad_d = bad_q + 1'b1;
          end
          if (pix_q == PIX_W'(FRAME_LEN - 1)) begin
            state_d = ST_WAIT_CNT;
            wd_clr  = 1'b1;
          end
        end
      end
      ST_WAIT_CNT: begin
        if (CNT_valid) begin
          state_d = ST_WAIT_CODE;
          wd_clr  = 1'b1;
        end else if (wd_exp) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT_CODE: begin
        if (code_valid) begin
          state_d = ST_DONE;
        end else if (wd_exp) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        fcnt_d  = fcnt_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end
    core_rst_d = (state_d == ST_CLR) || (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      clr_q      <= '0;
      core_rst_q <= 1'b1;
      gv_q       <= 1'b0;
      gd_q       <= '0;
      err_q      <= 1'b0;
      bad_q      <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      clr_q      <= clr_d;
      core_rst_q <= core_rst_d;
      gv_q       <= gv_d;
      gd_q       <= gd_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign core_rst   = core_rst_q;
  assign gray_valid = gv_q;
  assign gray_data  = gd_q;
  assign err        = err_q;
  assign bad_cnt    = bad_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench for huffman_frame_ctrl with a per-cycle
// reference model, a source queue and a simple core model.
module tb_huffman_frame_ctrl;

  localparam int FL   = 100;
  localparam int CLRC = 2;
  localparam int TO   = 255;

  localparam int P_IDLE  = 0;
  localparam int P_CLR   = 1;
  localparam int P_FEED  = 2;
  localparam int P_WCNT  = 3;
  localparam int P_WCODE = 4;
  localparam int P_DONE  = 5;
  localparam int P_ERR   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       core_rst;
  logic       gray_valid;
  logic [7:0] gray_data;
  logic       CNT_valid = 1'b0;
  logic       code_valid = 1'b0;
  logic       done;
  logic       err;
  logic [6:0] bad_cnt;
  logic [7:0] frame_cnt;

  huffman_frame_ctrl_if src_if ();

  huffman_frame_ctrl #(
    .FRAME_LEN  (FL),
    .CLR_CYCLES (CLRC),
    .TIMEOUT    (TO),
    .FCNT_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .src        (src_if),
    .core_rst   (core_rst),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .CNT_valid  (CNT_valid),
    .code_valid (code_valid),
    .done       (done),
    .err        (err),
    .bad_cnt    (bad_cnt),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Source: presents queue head until accepted.
  logic [7:0] src_q[$];
  int         vpct = 100;
  bit         tail_valid = 1'b0;

  initial begin
    src_if.src_valid = 1'b0;
    src_if.src_data  = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        src_if.src_data  = src_q[0];
        src_if.src_valid = ($urandom_range(99) < vpct);
      end else begin
        src_if.src_data  = 8'd7;
        src_if.src_valid = tail_valid;
      end
      @(negedge clk);
      if (src_if.src_valid && src_if.src_ready && src_q.size() > 0)
        void'(src_q.pop_front());
    end
  end

  // Core: CNT_valid one cycle, code_valid from eight cycles
  // after the last gray_valid of a frame.
  bit code_en = 1'b1;

  initial begin
    int gcnt;
    int since;
    gcnt  = 0;
    since = -1;
    forever begin
      @(posedge clk);
      #1;
      if (core_rst) begin
        gcnt       = 0;
        since      = -1;
        CNT_valid  = 1'b0;
        code_valid = 1'b0;
      end else begin
        if (since >= 0) since++;
        if (gray_valid) begin
          gcnt++;
          if (gcnt == FL) since = 0;
        end
        CNT_valid  = (since == 1);
        code_valid = code_en && (since >= 8);
      end
    end
  end

  // Reference model and per-cycle compare.
  int         ph = P_IDLE;
  int         clr_left = 0;
  int         pix = 0;
  int         wd = 0;
  bit         m_crst = 1'b1;
  bit         m_gv = 1'b0;
  logic [7:0] m_gd = 8'd0;
  bit         m_err = 1'b0;
  int         m_bad = 0;
  int         m_frames = 0;
  int         hs_cnt = 0;
  int         gv_cnt = 0;
  logic [7:0] rx_q[$];

  initial begin
    bit         hs;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      chk("busy", int'(busy), int'(ph != P_IDLE));
      chk("src_ready", int'(src_if.src_ready),
          int'(ph == P_FEED && pix < FL));
      chk("core_rst", int'(core_rst), int'(m_crst));
      chk("gray_valid", int'(gray_valid), int'(m_gv));
      chk("gray_data", int'(gray_data), int'(m_gd));
      chk("done", int'(done), int'(ph == P_DONE));
      chk("err", int'(err), int'(m_err));
      chk("bad_cnt", int'(bad_cnt), m_bad);
      chk("frame_cnt", int'(frame_cnt), m_frames);
      if (gray_valid) begin
        gv_cnt++;
        rx_q.push_back(gray_data);
      end

      d  = src_if.src_data;
      hs = (ph == P_FEED) && (pix < FL) && src_if.src_valid;
      if (reset) begin
        ph = P_IDLE; m_gv = 0; m_gd = 0; m_err = 0;
        m_bad = 0; m_frames = 0;
        m_crst = 1'b1;
      end else begin
        m_gv = hs;
        if (hs) begin
          m_gd = d;
          hs_cnt++;
        end
        case (ph)
          P_IDLE: if (start) begin
            ph = P_CLR; clr_left = CLRC;
            m_err = 0; m_bad = 0; pix = 0;
          end
          P_CLR: begin
            clr_left--;
            if (clr_left == 0) ph = P_FEED;
          end
          P_FEED: if (hs) begin
            pix++;
            if ((d == 0 || d > 6) && m_bad < 127) m_bad++;
            if (pix == FL) begin ph = P_WCNT; wd = 0; end
          end
          P_WCNT: begin
            if (CNT_valid) begin ph = P_WCODE; wd = 0; end
            else if (wd == TO - 1) ph = P_ERR;
            else wd++;
          end
          P_WCODE: begin
            if (code_valid) ph = P_DONE;
            else if (wd == TO - 1) ph = P_ERR;
            else wd++;
          end
          P_DONE: begin
            m_frames = (m_frames + 1) % 256;
            ph = P_IDLE;
          end
          default: ph = P_IDLE;
        endcase
        if (ph == P_ERR) m_err = 1'b1;
        m_crst = (ph == P_CLR) || (ph == P_ERR);
      end
    end
  end

  // Sequencer helpers: drive at posedge+1, check at negedge+1.
  logic [7:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_frame(input int kind);
    logic [7:0] v;
    exp_q.delete();
    for (int i = 0; i < FL; i++) begin
      v = 8'((kind == 2 ? i * 5 : i) % 6 + 1);
      if (kind == 1 && i >= 10 && i < 15) v = 8'd0;
      if (kind == 1 && (i == 20 || i == 30 || i == 40)) v = 8'd9;
      src_q.push_back(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      look();
      k++;
    end while (!done && k < budget);
    chk("done_wait", int'(done), 1);
  endtask

  initial begin
    int n;
    int bad_seq;

    repeat (3) step();
    look();
    chk("rst_core_rst", int'(core_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gray_valid", int'(gray_valid), 0);
    step();
    reset = 1'b0;
    step();
    look();
    chk("idle_core_rst", int'(core_rst), 0);
    chk("idle_frame_cnt", int'(frame_cnt), 0);

    // Nominal frame with clear-phase timing.
    load_frame(0);
    gv_cnt = 0;
    step();
    pulse_start();
    look();
    chk("clr1_core_rst", int'(core_rst), 1);
    step();
    look();
    chk("clr2_core_rst", int'(core_rst), 1);
    chk("clr2_src_ready", int'(src_if.src_ready), 0);
    step();
    look();
    chk("feed_src_ready", int'(src_if.src_ready), 1);
    chk("feed_core_rst", int'(core_rst), 0);
    wait_done(600);
    chk("A_gv_count", gv_cnt, 100);
    chk("A_bad_cnt", int'(bad_cnt), 0);
    chk("A_err", int'(err), 0);
    step();
    look();
    chk("A_frame_cnt", int'(frame_cnt), 1);

    // Stalling source, stray start in FEED, tail valid held.
    load_frame(2);
    vpct = 30;
    tail_valid = 1'b1;
    gv_cnt = 0;
    rx_q.delete();
    step();
    pulse_start();
    repeat (20) step();
    pulse_start();
    wait_done(4000);
    bad_seq = 0;
    for (int i = 0; i < FL; i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad_seq++;
    chk("B_seq_errors", bad_seq, 0);
    chk("B_gv_count", gv_cnt, 100);
    tail_valid = 1'b0;
    vpct = 100;
    step();
    look();
    chk("B_frame_cnt", int'(frame_cnt), 2);

    // Out-of-range symbols.
    load_frame(1);
    gv_cnt = 0;
    step();
    pulse_start();
    wait_done(600);
    chk("C_bad_cnt", int'(bad_cnt), 8);
    chk("C_gv_count", gv_cnt, 100);

    // Core never raises code_valid.
    code_en = 1'b0;
    load_frame(0);
    step();
    pulse_start();
    n = 0;
    do begin look(); n++; end while (!CNT_valid && n < 600);
    chk("D_cnt_valid_seen", int'(CNT_valid), 1);
    n = 0;
    do begin step(); look(); n++; end
      while (!core_rst && n < 400);
    chk("D_timeout_cycles", n, 256);
    step();
    look();
    chk("D_err", int'(err), 1);
    chk("D_busy", int'(busy), 0);
    chk("D_frame_cnt", int'(frame_cnt), 3);
    code_en = 1'b1;
    load_frame(0);
    step();
    pulse_start();
    look();
    chk("E_err_cleared", int'(err), 0);
    wait_done(600);
    step();
    look();
    chk("E_frame_cnt", int'(frame_cnt), 4);

    // Reset part-way through a frame.
    load_frame(0);
    step();
    hs_cnt = 0;
    pulse_start();
    n = 0;
    do begin look(); n++; end while (hs_cnt < 50 && n < 600);
    step();
    reset = 1'b1;
    src_q.delete();
    step();
    reset = 1'b0;
    look();
    chk("F_busy", int'(busy), 0);
    chk("F_core_rst", int'(core_rst), 1);
    chk("F_gray_valid", int'(gray_valid), 0);
    chk("F_frame_cnt", int'(frame_cnt), 0);
    step();
    load_frame(0);
    step();
    pulse_start();
    wait_done(600);
    step();
    look();
    chk("G_frame_cnt", int'(frame_cnt), 1);

    // Counter wrap over 256 back-to-back frames.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int f = 0; f < 256; f++) begin
      load_frame(0);
      pulse_start();
      wait_done(600);
      step();
    end
    look();
    chk("W_frame_cnt", int'(frame_cnt), 0);
    chk("W_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/huffman_frame_ctrl.md
# huffman_frame_ctrl

Frame sequencer for the Huffman encoder core. It takes grey pixels from an upstream valid/ready source and clears the core before every frame. It meters exactly `FRAME_LEN` pixels into the core, then tracks the core's `CNT_valid`/`code_valid` completion with a watchdog. It reports per-frame completion, timeout and out-of-range-symbol status to the system controller.

## Interface
Parameters:
- `FRAME_LEN`, 100: pixels per frame; must equal the core's internal frame length.
- `CLR_CYCLES`, 2: cycles `core_rst` is held before each frame (≥1).
- `TIMEOUT`, 255: maximum cycles spent in either wait state before error (≥2).
- `FCNT_W`, 8: width of the completed-frame counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `start`  in  1  request a frame; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `src_valid`  in  1  upstream pixel valid.
- `src_data`  in  8  upstream pixel.
- `src_ready`  out  1  pixel accepted when `src_valid & src_ready`.
- `core_rst`  out  1  registered reset to the core.
- `gray_valid`  out  1  registered pixel strobe to the core.
- `gray_data`  out  8  registered pixel to the core.
- `CNT_valid`  in  1  core histogram-complete.
- `code_valid`  in  1  core codes-ready (level; held until core reset).
- `done`  out  1  one-cycle pulse on successful frame.
- `err`  out  1  sticky timeout flag; cleared on accepted `start`.
- `bad_cnt`  out  7  pixels outside 1..6 in the current/last frame; saturates at 127; cleared on accepted `start`.
- `frame_cnt`  out  `FCNT_W`  successful frames, wraps modulo 2^FCNT_W.

## Operation
- States: IDLE, CLR, FEED, WAIT_CNT, WAIT_CODE, DONE, ERR.
- IDLE: `start`=1 → CLR. Clears `err` and `bad_cnt`, loads the clear counter, zeros the pixel counter.
- CLR: `core_rst`=1 for exactly `CLR_CYCLES` cycles → FEED.
- FEED:
  - `src_ready = (state==FEED) && (pix_cnt < FRAME_LEN)`, combinational.
  - Each handshake increments `pix_cnt` and registers `gray_valid`=1 and `gray_data`=`src_data` for the next cycle.
  - Otherwise `gray_valid`=0 and `gray_data` holds.
  - A pixel is out of range when `src_data`==0 or >6; it increments `bad_cnt` and is still forwarded.
  - The handshake making `pix_cnt`==`FRAME_LEN` → WAIT_CNT.
- WAIT_CNT: `CNT_valid`=1 → WAIT_CODE; watchdog expiry → ERR.
- WAIT_CODE: `code_valid`=1 → DONE; watchdog expiry → ERR.
- DONE: `done`=1, `frame_cnt`+1 → IDLE.
- ERR: set `err`, assert `core_rst` for this cycle → IDLE. `frame_cnt` is unchanged.
- Watchdog: cleared on entry to each wait state and incremented each cycle there. Expiry is when the count reaches `TIMEOUT-1`, giving exactly `TIMEOUT` cycles per wait state.
- `start` outside IDLE is ignored; requests are not queued.
- Stalls in FEED (`src_valid`=0) have no limit; the watchdog does not run in FEED.

## Timing
- Reset values:
  - state IDLE; `core_rst`=1, then 0 in the first IDLE cycle.
  - `gray_valid`=0, `gray_data`=0.
  - `src_ready`=0, `busy`=0, `done`=0, `err`=0.
  - `bad_cnt`=0, `frame_cnt`=0.
- `start` at cycle t → `core_rst` high during t+1..t+CLR_CYCLES → `src_ready` high at t+CLR_CYCLES+1.
- Pixel latency: handshake at cycle n → `gray_valid` at n+1.
- Back-to-back frame with zero source stall: the 100th handshake at n and the last `gray_valid` at n+1. The core's `CNT_valid` follows by its own counter latency.
- `done` is asserted in the cycle after `code_valid` is sampled high. IDLE follows, and a new `start` is accepted in that IDLE cycle.
- Synchronous reset mid-frame: next state IDLE with reset values. The core is cleared again by CLR on the next `start`.
- `CNT_valid` and `code_valid` are ignored outside their wait states.

## Structure
- Package `huffman_pkg`:
  - state enum `hf_ctrl_state_t`;
  - `SYM_MIN`=1, `SYM_MAX`=6;
  - default `FRAME_LEN`=100.
- Sub-module `huffman_wdog`: clear/enable counter with `expire` output, parameterised by `TIMEOUT`. It is instantiated once and shared by both wait states.

## Test plan
- Nominal: `start`; 100 pixels, `src_valid` always 1, values cycling 1..6; core model raises `CNT_valid` 1 cycle and `code_valid` 8 cycles after the last `gray_valid` → exactly 100 `gray_valid` pulses, one `done`, `frame_cnt`=1, `err`=0, `bad_cnt`=0.
- Stalling source: `src_valid` random 30%, 100 pixels → `gray_data` sequence identical to the source sequence, `src_ready` low after the 100th handshake, never a 101st handshake.
- Bad symbols: 5 pixels of value 0 and 3 of value 9 within a frame → `bad_cnt`=8 at `done`, all 100 pixels forwarded.
- Timeout: core never raises `code_valid` → ERR exactly 255 cycles after WAIT_CODE entry, `err`=1, `core_rst` pulse, `frame_cnt` unchanged; next `start` clears `err`.
- Robustness: `start` pulsed during FEED is ignored. `reset` asserted at pixel 50 → IDLE with reset values next cycle; a following frame completes normally with `frame_cnt`=1. 256 successful frames → `frame_cnt` wraps to 0.
